// File: rtl/fabric_pkg.sv
// Shared geometry, instruction-bus widths, header layout and loader states
// for the fabric program loader.
package fabric_pkg;

    localparam int ROWS             = 3;
    localparam int COLS             = 4;
    localparam int INSTR_DATA_WIDTH = 16;
    localparam int INSTR_ADDR_WIDTH = 3;
    localparam int INSTR_HOPS_WIDTH = 3;

    localparam int ROW_W       = $clog2(ROWS);
    localparam int HDR_ROW_LSB = 0;
    localparam int HDR_COL_LSB = HDR_ROW_LSB + ROW_W;

    localparam int unsigned TIMEOUT_DEFAULT = 32'd1 << 20;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALL,
        SETTLE,
        WAIT_RET,
        DONE
    } state_t;

endpackage

// File: rtl/fabric_loader.sv
// Streams a header/instruction program into the fabric rows, then calls
// the rows and times how long they take to return.
module fabric_loader #(
    parameter int          ROWS             = fabric_pkg::ROWS,
    parameter int          COLS             = fabric_pkg::COLS,
    parameter int          INSTR_DATA_WIDTH = fabric_pkg::INSTR_DATA_WIDTH,
    parameter int          INSTR_ADDR_WIDTH = fabric_pkg::INSTR_ADDR_WIDTH,
    parameter int          INSTR_HOPS_WIDTH = fabric_pkg::INSTR_HOPS_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES   = fabric_pkg::TIMEOUT_DEFAULT
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     prog_valid,
    output logic                                     prog_ready,
    input  logic                                     prog_hdr,
    input  logic                                     prog_last,
    input  logic [INSTR_DATA_WIDTH-1:0]              prog_data,
    output logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]    instr_data_out,
    output logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]    instr_addr_out,
    output logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]    instr_hops_out,
    output logic [ROWS-1:0]                          instr_en_out,
    output logic [ROWS-1:0]                          call,
    input  logic [ROWS-1:0]                          ret,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     error,
    output logic [31:0]                              cycle_count
);
    import fabric_pkg::*;

    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int HW      = INSTR_HOPS_WIDTH;
    localparam int COL_LSB = HDR_ROW_LSB + RW;

    localparam logic [RW:0] ROW_LIM    = (RW + 1)'(ROWS);
    localparam logic [HW:0] COL_LIM    = (HW + 1)'(COLS);
    localparam logic [31:0] SETTLE_END = 32'(2 * COLS);

    state_t state, state_n;

    logic [RW-1:0]               cur_row;
    logic [HW-1:0]               cur_col;
    logic [INSTR_ADDR_WIDTH-1:0] index;
    logic                        hdr_seen;
    logic                        idx_full;
    logic                        last_seen;

    logic          fire;
    logic          hdr_bad;
    logic          instr_ok;
    logic          timeout_hit;
    logic [RW-1:0] hdr_row;
    logic [HW-1:0] hdr_col;

    assign fire        = (state == LOAD) && prog_valid && prog_ready;
    assign hdr_row     = prog_data[HDR_ROW_LSB +: RW];
    assign hdr_col     = prog_data[COL_LSB +: HW];
    assign hdr_bad     = ({1'b0, hdr_row} >= ROW_LIM) ||
                         ({1'b0, hdr_col} >= COL_LIM);
    assign instr_ok    = hdr_seen && !idx_full;
    assign timeout_hit = (cycle_count + 32'd1) >= TIMEOUT_CYCLES;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // LOAD lingers one cycle after the last word so its pulse precedes call.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (start) state_n = LOAD;
            LOAD:     if (last_seen) state_n = CALL;
            CALL:     state_n = SETTLE;
            SETTLE:   if (cycle_count == SETTLE_END) state_n = WAIT_RET;
            WAIT_RET: if ((&ret) || timeout_hit) state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prog_ready     <= 1'b0;
            instr_en_out   <= '0;
            instr_data_out <= '0;
            instr_addr_out <= '0;
            instr_hops_out <= '0;
            call           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            cycle_count    <= '0;
            cur_row        <= '0;
            cur_col        <= '0;
            index          <= '0;
            hdr_seen       <= 1'b0;
            idx_full       <= 1'b0;
            last_seen      <= 1'b0;
        end else begin
            instr_en_out   <= '0;
            instr_data_out <= '0;
            instr_addr_out <= '0;
            instr_hops_out <= '0;
            prog_ready     <= (state_n == LOAD) && !(fire && prog_last);
            call           <= {ROWS{state_n == CALL}};
            busy           <= (state_n != IDLE);
            done           <= (state_n == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        error     <= 1'b0;
                        cur_row   <= '0;
                        cur_col   <= '0;
                        index     <= '0;
                        hdr_seen  <= 1'b0;
                        idx_full  <= 1'b0;
                        last_seen <= 1'b0;
                    end
                end
                LOAD: begin
                    if (fire) begin
                        if (prog_last) last_seen <= 1'b1;
                        if (prog_hdr) begin
                            if (hdr_bad) begin
                                error    <= 1'b1;
                                hdr_seen <= 1'b0;
                            end else begin
                                cur_row  <= hdr_row;
                                cur_col  <= hdr_col;
                                index    <= '0;
                                idx_full <= 1'b0;
                                hdr_seen <= 1'b1;
                            end
                        end else if (instr_ok) begin
                            instr_en_out[cur_row]   <= 1'b1;
                            instr_data_out[cur_row] <= prog_data;
                            instr_addr_out[cur_row] <= index;
                            instr_hops_out[cur_row] <= cur_col;
                            if (&index) idx_full <= 1'b1;
                            else index <= index + 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    if (last_seen) cycle_count <= '0;
                end
                CALL, SETTLE: begin
                    cycle_count <= cycle_count + 32'd1;
                end
                WAIT_RET: begin
                    cycle_count <= cycle_count + 32'd1;
                    if (!(&ret) && timeout_hit) error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_loader.sv
// Directed bench for fabric_loader: load patterns, error paths, ret timing,
// timeout and mid-load reset, each checked by immediate assertions.
module tb_fabric_loader;
    import fabric_pkg::*;

    localparam int DW = INSTR_DATA_WIDTH;
    localparam int AW = INSTR_ADDR_WIDTH;
    localparam int HW = INSTR_HOPS_WIDTH;

    logic                         clk;
    logic                         rst;
    logic                         start;
    logic                         prog_valid;
    logic                         prog_ready;
    logic                         prog_hdr;
    logic                         prog_last;
    logic [DW-1:0]                prog_data;
    logic [ROWS-1:0][DW-1:0]      instr_data_out;
    logic [ROWS-1:0][AW-1:0]      instr_addr_out;
    logic [ROWS-1:0][HW-1:0]      instr_hops_out;
    logic [ROWS-1:0]              instr_en_out;
    logic [ROWS-1:0]              call;
    logic [ROWS-1:0]              ret;
    logic                         busy;
    logic                         done;
    logic                         error;
    logic [31:0]                  cycle_count;

    int n_cmp = 0;
    int n_bad = 0;

    fabric_loader #(.TIMEOUT_CYCLES(100)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .prog_valid     (prog_valid),
        .prog_ready     (prog_ready),
        .prog_hdr       (prog_hdr),
        .prog_last      (prog_last),
        .prog_data      (prog_data),
        .instr_data_out (instr_data_out),
        .instr_addr_out (instr_addr_out),
        .instr_hops_out (instr_hops_out),
        .instr_en_out   (instr_en_out),
        .call           (call),
        .ret            (ret),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .cycle_count    (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] hw(input int row, input int col);
        return DW'((col << ROW_W) | row);
    endfunction

    task automatic word(input logic h, input logic l, input logic [DW-1:0] d);
        chk("ready", 64'(prog_ready), 64'(1));
        prog_valid = 1'b1;
        prog_hdr   = h;
        prog_last  = l;
        prog_data  = d;
        tick();
        prog_valid = 1'b0;
        prog_hdr   = 1'b0;
        prog_last  = 1'b0;
    endtask

    task automatic chk_pulse(input string tag, input int row,
                             input logic [DW-1:0] d, input int a, input int h);
        chk({tag, " en"}, 64'(instr_en_out), 64'(1) << row);
        chk({tag, " data"}, 64'(instr_data_out), 64'(d) << (row * DW));
        chk({tag, " addr"}, 64'(instr_addr_out), 64'(a) << (row * AW));
        chk({tag, " hops"}, 64'(instr_hops_out), 64'(h) << (row * HW));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " en"}, 64'(instr_en_out), 64'(0));
        chk({tag, " data"}, 64'(instr_data_out), 64'(0));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start busy", 64'(busy), 64'(1));
        chk("start ready", 64'(prog_ready), 64'(1));
        chk("start error", 64'(error), 64'(0));
    endtask

    // Entered in the cycle showing the last word's output.
    task automatic finish_run(input string tag, input int ret_at,
                              input int exp_cnt, input logic exp_err);
        int  k;
        bit  got;
        chk({tag, " drain ready"}, 64'(prog_ready), 64'(0));
        tick();
        chk({tag, " call"}, 64'(call), 64'(3'b111));
        chk({tag, " call quiet"}, 64'(instr_en_out), 64'(0));
        chk({tag, " call cnt"}, 64'(cycle_count), 64'(0));
        k   = 0;
        got = 1'b0;
        if (ret_at == 0) ret = '1;
        while (!got && k < 400) begin
            tick();
            k++;
            if (k == 1) chk({tag, " call once"}, 64'(call), 64'(0));
            if (done) got = 1'b1;
            else if (k == ret_at) ret = '1;
        end
        chk({tag, " done seen"}, 64'(got), 64'(1));
        chk({tag, " done cycle"}, 64'(k), 64'(exp_cnt));
        chk({tag, " count"}, 64'(cycle_count), 64'(exp_cnt));
        chk({tag, " error"}, 64'(error), 64'(exp_err));
        chk({tag, " busy at done"}, 64'(busy), 64'(1));
        tick();
        ret = '0;
        chk({tag, " done width"}, 64'(done), 64'(0));
        chk({tag, " idle busy"}, 64'(busy), 64'(0));
        chk({tag, " count hold"}, 64'(cycle_count), 64'(exp_cnt));
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        prog_valid = 1'b0;
        prog_hdr   = 1'b0;
        prog_last  = 1'b0;
        prog_data  = '0;
        ret        = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst ready", 64'(prog_ready), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst call", 64'(call), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst error", 64'(error), 64'(0));
        chk("rst count", 64'(cycle_count), 64'(0));
        chk_quiet("rst");

        // header(0,1) then three instructions
        do_start();
        word(1'b1, 1'b0, hw(0, 1));
        chk_quiet("p1 hdr");
        word(1'b0, 1'b0, 16'hA001);
        chk_pulse("p1 i0", 0, 16'hA001, 0, 1);
        word(1'b0, 1'b0, 16'hA002);
        chk_pulse("p1 i1", 0, 16'hA002, 1, 1);
        word(1'b0, 1'b1, 16'hA003);
        chk_pulse("p1 i2", 0, 16'hA003, 2, 1);
        finish_run("p1", 0, 10, 1'b0);

        // two cells; a stray start mid-load must not restart anything
        do_start();
        word(1'b1, 1'b0, hw(1, 0));
        word(1'b0, 1'b0, 16'hB010);
        chk_pulse("p2 r1a0", 1, 16'hB010, 0, 0);
        start = 1'b1;
        word(1'b0, 1'b0, 16'hB011);
        start = 1'b0;
        chk_pulse("p2 r1a1", 1, 16'hB011, 1, 0);
        word(1'b1, 1'b0, hw(0, 2));
        word(1'b0, 1'b1, 16'hB020);
        chk_pulse("p2 r0a0", 0, 16'hB020, 0, 2);
        chk("p2 error", 64'(error), 64'(0));
        finish_run("p2", 0, 10, 1'b0);

        // instruction before any header
        do_start();
        word(1'b0, 1'b0, 16'hDEAD);
        chk_quiet("p3 orphan");
        chk("p3 orphan error", 64'(error), 64'(1));
        word(1'b1, 1'b0, hw(0, 0));
        word(1'b0, 1'b1, 16'hC000);
        chk_pulse("p3 r0a0", 0, 16'hC000, 0, 0);
        finish_run("p3", 0, 10, 1'b1);

        // ret raised 50 cycles after call
        do_start();
        word(1'b1, 1'b0, hw(2, 3));
        word(1'b0, 1'b1, 16'h5A5A);
        chk_pulse("p4 r2", 2, 16'h5A5A, 0, 3);
        finish_run("p4 ret50", 50, 51, 1'b0);

        // ret never rises
        do_start();
        word(1'b1, 1'b0, hw(1, 2));
        word(1'b0, 1'b1, 16'h0777);
        chk_pulse("p5 r1", 1, 16'h0777, 0, 2);
        finish_run("p5 timeout", -1, 100, 1'b1);

        // out-of-range header, then last arriving on a dropped word
        do_start();
        word(1'b1, 1'b0, hw(1, 4));
        chk_quiet("p6 badhdr");
        chk("p6 badhdr error", 64'(error), 64'(1));
        word(1'b0, 1'b0, 16'h1111);
        chk_quiet("p6 drop");
        word(1'b0, 1'b1, 16'h2222);
        chk_quiet("p6 drop last");
        finish_run("p6", 0, 10, 1'b1);

        // index saturation at the top address
        do_start();
        word(1'b1, 1'b0, hw(0, 0));
        for (int i = 0; i < 8; i++) begin
            word(1'b0, 1'b0, DW'(16'h0100 + i));
            chk_pulse("p7 fill", 0, DW'(16'h0100 + i), i, 0);
        end
        chk("p7 full error", 64'(error), 64'(0));
        word(1'b0, 1'b1, 16'h01FF);
        chk_quiet("p7 overflow");
        chk("p7 overflow error", 64'(error), 64'(1));
        finish_run("p7", 0, 10, 1'b1);

        // reset in the middle of a load
        do_start();
        word(1'b0, 1'b0, 16'hBAD0);
        word(1'b1, 1'b0, hw(1, 1));
        word(1'b0, 1'b0, 16'hE000);
        word(1'b0, 1'b0, 16'hE001);
        chk_pulse("p8 pre", 1, 16'hE001, 1, 1);
        prog_valid = 1'b1;
        prog_data  = 16'hE002;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        prog_valid = 1'b0;
        chk_quiet("p8 rst");
        chk("p8 rst ready", 64'(prog_ready), 64'(0));
        chk("p8 rst busy", 64'(busy), 64'(0));
        chk("p8 rst error", 64'(error), 64'(0));
        chk("p8 rst count", 64'(cycle_count), 64'(0));
        chk("p8 rst call", 64'(call), 64'(0));
        chk("p8 rst done", 64'(done), 64'(0));
        do_start();
        word(1'b1, 1'b0, hw(1, 1));
        word(1'b0, 1'b1, 16'hF000);
        chk_pulse("p8 reload", 1, 16'hF000, 0, 1);
        finish_run("p8", 0, 10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fabric_loader.md
FABRIC_LOADER -- requirements
Module: fabric_loader

Interface
REQ-001 Parameters (values from fabric_pkg):
- ROWS, COLS, INSTR_DATA_WIDTH, INSTR_ADDR_WIDTH, INSTR_HOPS_WIDTH: fabric geometry and instruction-bus widths.
- TIMEOUT_CYCLES, default 2^20: maximum wait for ret after call.
REQ-002 Ports, in order (name, direction, width, meaning):
- clk  in  1  single clock.
- rst  in  1  reset; one clock, reset synchronous and active-high.
- start  in  1  one-cycle request to begin a program load.
- prog_valid  in  1  program word valid.
- prog_ready  out  1  loader accepts the program word.
- prog_hdr  in  1  word is a cell header, not an instruction.
- prog_last  in  1  final word of the program.
- prog_data  in  INSTR_DATA_WIDTH  instruction, or header {col[INSTR_HOPS_WIDTH], row[ROW_W]} in the LSBs.
- instr_data_out, instr_addr_out, instr_hops_out, instr_en_out  out  ROWS x (DATA / ADDR / HOPS / 1)  per-row instruction bus to the fabric.
- call  out  ROWS  start pulse to the fabric rows.
- ret  in  ROWS  row completion flags.
- busy  out  1  loader is not idle.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky error flag, cleared by start.
- cycle_count  out  32  cycles from call to completion.

Function
REQ-003 FSM states: IDLE, LOAD, CALL, SETTLE, WAIT_RET, DONE; all outputs registered.
REQ-004 IDLE: start=1 -> LOAD; clear error, cur_row, cur_col, index, hdr_seen; busy=1 from the next cycle.
REQ-005 prog_ready=1 only in LOAD; a word is consumed on prog_valid&&prog_ready at the clock edge; throughput is one word per cycle.
REQ-006 Header word: latch cur_row and cur_col, set index=0 and hdr_seen=1; no instr_en_out pulse.
REQ-007 Instruction word: in the next cycle, drive the following for exactly one cycle:
- instr_en_out[cur_row]=1, instr_data_out[cur_row]=prog_data, instr_addr_out[cur_row]=index, instr_hops_out[cur_row]=cur_col.
- Then increment index.
- All other rows' buses are 0.
REQ-008 Instruction word with hdr_seen=0: drop it and set error.
REQ-009 Header with row>=ROWS or col>=COLS: set error and clear hdr_seen, so following words are dropped.
REQ-010 Instruction word with index = 2^INSTR_ADDR_WIDTH-1: emit it, then saturate index; later words for that cell are dropped and set error.
REQ-011 Instruction buses are 0 whenever instr_en_out is 0.
REQ-012 prog_last consumed (header or instruction) -> CALL after that word's output cycle.
REQ-013 CALL: call=all ones for exactly one cycle; cycle_count cleared to 0 in this cycle -> SETTLE.
REQ-014 SETTLE: wait 2*COLS cycles, ignoring ret -> WAIT_RET.
REQ-015 cycle_count increments every cycle in SETTLE and WAIT_RET.
REQ-016 WAIT_RET: &ret=1 -> DONE, freezing cycle_count.
REQ-017 WAIT_RET: cycle_count reaching TIMEOUT_CYCLES -> set error, then DONE.
REQ-018 DONE: done=1 for one cycle, busy=0 from the next cycle -> IDLE; cycle_count holds until the next start.
REQ-019 start outside IDLE is ignored; prog_valid outside LOAD is ignored (prog_ready=0).
REQ-020 Simultaneous prog_last and an error condition: the word is dropped, error is set, and the FSM still goes to CALL.

Reset
REQ-021 rst=1 at a clock edge forces, next cycle, in any state including mid-LOAD or WAIT_RET:
- FSM to IDLE.
- prog_ready, instr_*_out, call, busy, done, error, cycle_count, index, hdr_seen all 0.

Structure
REQ-022 fabric_pkg holds ROWS, COLS, the INSTR_* widths, ROW_W=$clog2(ROWS), the header field offsets, and the FSM state enum typedef.
REQ-023 The module is a single module with no sub-modules; it drops into fabric_tb in place of the file-driven load loop.

Verification
REQ-024 Program: header(0,1), 3 instructions, last on the third. Require:
- instr_en_out[0] pulses on 3 consecutive cycles with addr 0,1,2 and hops=1.
- call=all ones one cycle after the third pulse.
REQ-025 Program: header(1,0), 2 instructions, header(0,2), 1 instruction, last. Require:
- Row 1 gets addr 0,1 with hops 0.
- Row 0 gets addr 0 with hops 2.
- error=0.
REQ-026 Instruction before any header, then header(0,0), 1 instruction, last. Require:
- First word dropped, error=1.
- One pulse on row 0 with addr 0.
- Load completes normally.
REQ-027 ret held 0, then all ret bits raised 50 cycles after call. Require:
- done pulses one cycle after &ret is sampled.
- cycle_count = 2*COLS + (50 - 2*COLS) + 1 = 51.
REQ-028 TIMEOUT_CYCLES=100 with ret stuck at 0. Require: error=1 and done pulses at cycle_count=100.
REQ-029 rst=1 asserted mid-LOAD after 2 instructions. Require:
- All outputs 0 next cycle.
- A fresh start reloads from addr 0.
